// File: rtl/mc8123_fetch_ctrl.sv
// Z80 fetch sequencer for the MC8123 decryptor: ROM fetch, key-RAM lookup and key download.
// Define MC8123_FETCH_CACHE_EN to build the one-entry {address, m1, plaintext} fetch cache.
module mc8123_fetch_ctrl #(
    parameter logic [15:0] ENC_TOP      = 16'hC000,
    parameter int          ROM_WAIT_MAX = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] cpu_a,
    input  logic        cpu_m1_n,
    input  logic        cpu_mreq_n,
    input  logic        cpu_rd_n,
    output logic        cpu_wait_n,
    output logic [7:0]  cpu_di,
    output logic        rom_req,
    output logic [15:0] rom_addr,
    input  logic        rom_ack,
    input  logic [7:0]  rom_data,
    output logic        dec_m1,
    output logic [15:0] dec_a,
    output logic [7:0]  dec_prog_d,
    input  logic [12:0] dec_key_a,
    output logic [7:0]  dec_key_d,
    input  logic [7:0]  dec_d,
    input  logic        dl_active,
    input  logic        dl_wr,
    input  logic [12:0] dl_addr,
    input  logic [7:0]  dl_data,
    output logic        key_valid,
    output logic        rom_timeout
);
    localparam int            TW       = $clog2(ROM_WAIT_MAX + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(ROM_WAIT_MAX - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_KEY  = 3'd2;
    localparam logic [2:0] S_DEC  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    cpu_di_q, cpu_di_d;
    logic [15:0]   addr_q, addr_d;
    logic          m1_q, m1_d;
    logic [7:0]    prog_q, prog_d;
    logic [7:0]    key_q;
    logic          key_valid_q, key_valid_d;
    logic          timeout_q, timeout_d;
    logic          dl_active_q;
    logic [7:0]    key_ram [0:8191];

    logic          fetch_start, encrypted, dl_rise, key_rd, req_expire, cache_hit;
    logic [7:0]    cache_d;

    // Reset gates the start decode so WAIT is released while reset is held mid-fetch.
    assign fetch_start = reset_n && (state_q == S_IDLE) && !cpu_mreq_n && !cpu_rd_n;
    assign encrypted   = key_valid_q && (addr_q < ENC_TOP);
    assign dl_rise     = dl_active && !dl_active_q;
    assign key_rd      = (state_q == S_KEY) && !dl_wr;
    assign req_expire  = (state_q == S_REQ) && !rom_ack && (tmo_q == TMO_LAST);

`ifdef MC8123_FETCH_CACHE_EN
    logic        cache_vld_q, cache_m1_q, fill_en;
    logic [15:0] cache_a_q;
    logic [7:0]  cache_d_q;

    assign cache_hit = cache_vld_q && (cache_a_q == cpu_a) && (cache_m1_q == ~cpu_m1_n);
    assign cache_d   = cache_d_q;
    assign fill_en   = (state_q == S_DEC) || ((state_q == S_REQ) && rom_ack && !encrypted);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cache_vld_q <= 1'b0;
            cache_a_q   <= 16'h0000;
            cache_m1_q  <= 1'b0;
            cache_d_q   <= 8'h00;
        end else if (dl_wr || dl_rise || req_expire) begin
            cache_vld_q <= 1'b0;
        end else if (fill_en) begin
            cache_vld_q <= 1'b1;
            cache_a_q   <= addr_q;
            cache_m1_q  <= m1_q;
            cache_d_q   <= cpu_di_d;
        end
    end
`else
    assign cache_hit = 1'b0;
    assign cache_d   = 8'hFF;
`endif

    always_comb begin
        state_d     = state_q;
        tmo_d       = tmo_q;
        cpu_di_d    = cpu_di_q;
        addr_d      = addr_q;
        m1_d        = m1_q;
        prog_d      = prog_q;
        timeout_d   = timeout_q;
        key_valid_d = key_valid_q;
        case (state_q)
            S_IDLE: begin
                if (fetch_start) begin
                    addr_d = cpu_a;
                    m1_d   = ~cpu_m1_n;
                    tmo_d  = '0;
                    if (cache_hit) begin
                        cpu_di_d = cache_d;
                        state_d  = S_DONE;
                    end else begin
                        state_d  = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (rom_ack) begin
                    if (encrypted) begin
                        prog_d  = rom_data;
                        state_d = S_KEY;
                    end else begin
                        cpu_di_d = rom_data;
                        state_d  = S_DONE;
                    end
                end else if (req_expire) begin
                    timeout_d = 1'b1;
                    cpu_di_d  = 8'hFF;
                    state_d   = S_DONE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            // A download write owns the key RAM port; the lookup retries next cycle.
            S_KEY:   if (!dl_wr) state_d = S_DEC;
            S_DEC: begin
                cpu_di_d = dec_d;
                state_d  = S_DONE;
            end
            S_DONE:  if (cpu_rd_n || cpu_mreq_n) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (dl_rise) key_valid_d = 1'b0;
        if (dl_wr && dl_active && (dl_addr == 13'h1FFF)) key_valid_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (dl_wr) key_ram[dl_addr] <= dl_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            tmo_q       <= '0;
            cpu_di_q    <= 8'hFF;
            addr_q      <= 16'h0000;
            m1_q        <= 1'b0;
            prog_q      <= 8'h00;
            key_q       <= 8'h00;
            key_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            dl_active_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            cpu_di_q    <= cpu_di_d;
            addr_q      <= addr_d;
            m1_q        <= m1_d;
            prog_q      <= prog_d;
            key_valid_q <= key_valid_d;
            timeout_q   <= timeout_d;
            dl_active_q <= dl_active;
            if (key_rd) key_q <= key_ram[dec_key_a];
        end
    end

    assign cpu_wait_n  = !((fetch_start && !cache_hit) ||
                           (state_q == S_REQ) || (state_q == S_KEY) || (state_q == S_DEC));
    assign cpu_di      = cpu_di_q;
    assign rom_req     = (state_q == S_REQ);
    assign rom_addr    = addr_q;
    assign dec_a       = addr_q;
    assign dec_m1      = m1_q;
    assign dec_prog_d  = prog_q;
    assign dec_key_d   = key_q;
    assign key_valid   = key_valid_q;
    assign rom_timeout = timeout_q;
endmodule

// File: tb/tb_mc8123_fetch_ctrl.sv
// Bench for mc8123_fetch_ctrl: transaction-level timing/data model plus an external decryptor stand-in.
module tb_mc8123_fetch_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic [15:0] cpu_a;
    logic        cpu_m1_n, cpu_mreq_n, cpu_rd_n, cpu_wait_n;
    logic [7:0]  cpu_di;
    logic        rom_req, rom_ack;
    logic [15:0] rom_addr, dec_a;
    logic [7:0]  rom_data, dec_prog_d, dec_key_d, dec_d, dl_data;
    logic        dec_m1, dl_active, dl_wr, key_valid, rom_timeout;
    logic [12:0] dec_key_a, dl_addr;

    mc8123_fetch_ctrl dut (
        .clk(clk), .reset_n(reset_n), .cpu_a(cpu_a), .cpu_m1_n(cpu_m1_n),
        .cpu_mreq_n(cpu_mreq_n), .cpu_rd_n(cpu_rd_n), .cpu_wait_n(cpu_wait_n),
        .cpu_di(cpu_di), .rom_req(rom_req), .rom_addr(rom_addr), .rom_ack(rom_ack),
        .rom_data(rom_data), .dec_m1(dec_m1), .dec_a(dec_a), .dec_prog_d(dec_prog_d),
        .dec_key_a(dec_key_a), .dec_key_d(dec_key_d), .dec_d(dec_d),
        .dl_active(dl_active), .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data),
        .key_valid(key_valid), .rom_timeout(rom_timeout)
    );

`ifdef MC8123_FETCH_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    int n_chk = 0, n_fail = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Decryptor stand-in: key index is the low address bits, result registered on the falling edge.
    function automatic logic [7:0] dec_fn(logic m1, logic [15:0] a, logic [7:0] k, logic [7:0] c);
        return c ^ k ^ a[7:0] ^ a[15:8] ^ (m1 ? 8'h80 : 8'h00);
    endfunction
    assign dec_key_a = dec_a[12:0];
    initial dec_d = 8'h00;
    always @(negedge clk) dec_d <= dec_fn(dec_m1, dec_a, dec_key_d, dec_prog_d);

    // Model state
    logic [7:0]  key_m [0:8191];
    bit          kv_m, c_vld, c_m1, act, chk_en, m1_exp;
    logic [15:0] c_a, a_exp;
    logic [7:0]  c_d, prog_m, d_exp;
    int          w_from, w_to, r_from, r_to, d_from, a_from, wlo_cnt;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && reset_n) begin
            if (!cpu_wait_n) wlo_cnt++;
            check("cpu_wait_n", cpu_wait_n, !(act && cyc >= w_from && cyc < w_to));
            check("rom_req", rom_req, act && cyc >= r_from && cyc <= r_to);
            if (act && cyc >= r_from && cyc <= r_to) check("rom_addr", rom_addr, a_exp);
            if (act && cyc >= a_from) begin
                check("dec_a", dec_a, a_exp);
                check("dec_m1", dec_m1, m1_exp);
            end
            if (act && cyc >= d_from) check("cpu_di", cpu_di, d_exp);
        end
    end

    // n_ack: cycles from rom_req rising to the edge that samples rom_ack (0 = never acknowledged).
    task automatic do_fetch(input logic [15:0] a, input logic m1, input logic [7:0] rb,
                            input int n_ack, input int n_col, input logic [7:0] col_d);
        int t0, t_ack;
        bit enc, hit, tmo;
        @(posedge clk); #1;
        t0    = cyc;
        hit   = CACHE && c_vld && c_a == a && c_m1 == m1;
        enc   = kv_m && a < 16'hC000;
        tmo   = (n_ack == 0);
        t_ack = t0 + n_ack;
        if (n_col > 0) begin
            key_m[a[12:0]] = col_d;
            c_vld = 1'b0;
        end
        if (hit) begin
            w_from = 0; w_to = 0; r_from = 1; r_to = 0; d_from = t0 + 1; d_exp = c_d;
        end else if (tmo) begin
            w_from = t0; w_to = t0 + 256; r_from = t0 + 1; r_to = t0 + 255;
            d_from = w_to; d_exp = 8'hFF;
        end else begin
            w_from = t0; r_from = t0 + 1; r_to = t_ack;
            w_to   = enc ? t_ack + 3 + n_col : t_ack + 1;
            d_from = w_to;
            d_exp  = enc ? dec_fn(m1, a, key_m[a[12:0]], rb) : rb;
        end
        a_exp = a; m1_exp = m1; a_from = t0 + 1; wlo_cnt = 0; act = 1'b1;
        cpu_a = a; cpu_m1_n = !m1; cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0;
        dl_addr = a[12:0]; dl_data = col_d;
        forever begin
            @(posedge clk); #1;
            rom_ack  = !tmo && !hit && (cyc == t_ack);
            rom_data = rom_ack ? rb : 8'hEE;
            dl_wr    = (n_col > 0) && (cyc > t_ack) && (cyc <= t_ack + n_col);
            if (cyc == d_from + 1) begin
                cpu_mreq_n = 1'b1; cpu_rd_n = 1'b1;
                rom_ack = 1'b1; rom_data = 8'h00;   // stray ack outside REQ
            end
            if (cyc >= d_from + 2) begin
                rom_ack = 1'b0; act = 1'b0;
                break;
            end
        end
        if (!hit && !tmo && enc) prog_m = rb;
        check("dec_prog_d", dec_prog_d, prog_m);
        if (tmo) c_vld = 1'b0;
        else begin
            c_vld = 1'b1; c_a = a; c_m1 = m1; c_d = d_exp;
        end
    endtask

    task automatic load_key(input logic [7:0] v);
        @(posedge clk); #1;
        dl_active = 1'b1;
        c_vld = 1'b0;
        for (int i = 0; i < 8192; i++) begin
            @(posedge clk); #1;
            if (i == 0) check("key_valid_cleared_on_rise", key_valid, 1'b0);
            dl_wr = 1'b1; dl_addr = 13'(i); dl_data = v; key_m[i] = v;
        end
        @(posedge clk); #1;
        dl_wr = 1'b0; dl_active = 1'b0; kv_m = 1'b1;
        check("key_valid_after_load", key_valid, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        cpu_a = 16'h0; cpu_m1_n = 1'b1; cpu_mreq_n = 1'b1; cpu_rd_n = 1'b1;
        rom_ack = 1'b0; rom_data = 8'h00; dl_active = 1'b0; dl_wr = 1'b0;
        dl_addr = 13'h0; dl_data = 8'h00;
        chk_en = 1'b0; act = 1'b0; kv_m = 1'b0; c_vld = 1'b0; c_m1 = 1'b0;
        c_a = 16'h0; c_d = 8'h0; prog_m = 8'h00; d_exp = 8'h0; a_exp = 16'h0; m1_exp = 1'b0;
        w_from = 0; w_to = 0; r_from = 1; r_to = 0; d_from = 0; a_from = 0; wlo_cnt = 0;
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_cpu_wait_n", cpu_wait_n, 1'b1);
        check("rst_cpu_di", cpu_di, 8'hFF);
        check("rst_rom_req", rom_req, 1'b0);
        check("rst_rom_addr", rom_addr, 16'h0);
        check("rst_dec_a", dec_a, 16'h0);
        check("rst_dec_m1", dec_m1, 1'b0);
        check("rst_dec_prog_d", dec_prog_d, 8'h0);
        check("rst_dec_key_d", dec_key_d, 8'h0);
        check("rst_key_valid", key_valid, 1'b0);
        check("rst_rom_timeout", rom_timeout, 1'b0);
        reset_n = 1'b1;
        chk_en = 1'b1;

        // No key loaded: bypass
        do_fetch(16'h0100, 1'b1, 8'h77, 2, 0, 8'h00);
        check("bypass_nokey_di", cpu_di, 8'h77);

        load_key(8'hFF);

        do_fetch(16'h0000, 1'b1, 8'h3C, 4, 0, 8'h00);
        check("enc_di_literal", cpu_di, 8'h43);
        check("enc_wait_low_cycles", wlo_cnt, 7);

        do_fetch(16'hC123, 1'b1, 8'h5A, 3, 0, 8'h00);
        check("above_top_di", cpu_di, 8'h5A);
        check("above_top_prog_kept", dec_prog_d, 8'h3C);
        check("above_top_wait_low", wlo_cnt, 4);

        do_fetch(16'h0005, 1'b0, 8'h11, 1, 1, 8'hA5);
        check("collide_di_literal", cpu_di, 8'hB1);
        check("collide_wait_low", wlo_cnt, 5);

        do_fetch(16'h0006, 1'b1, 8'h00, 3, 2, 8'h3C);
        check("collide2_di_literal", cpu_di, 8'hBA);

        do_fetch(16'h1234, 1'b1, 8'hF0, 2, 0, 8'h00);
        check("enc_1234_di_literal", cpu_di, 8'hA9);

        do_fetch(16'h0200, 1'b0, 8'h99, 0, 0, 8'h00);
        check("timeout_di", cpu_di, 8'hFF);
        check("timeout_flag", rom_timeout, 1'b1);
        check("timeout_req_low", rom_req, 1'b0);

        // key_valid: cleared on dl_active rise, set only by a 1FFF write while active
        @(posedge clk); #1; dl_active = 1'b1;
        @(posedge clk); #1; dl_active = 1'b0;
        check("kv_clear_on_rise", key_valid, 1'b0);
        dl_wr = 1'b1; dl_addr = 13'h1FFF; dl_data = 8'hFF; c_vld = 1'b0;
        @(posedge clk); #1; dl_wr = 1'b0;
        check("kv_not_set_inactive", key_valid, 1'b0);
        dl_active = 1'b1;
        @(posedge clk); #1;
        dl_wr = 1'b1;
        @(posedge clk); #1;
        dl_wr = 1'b0; dl_active = 1'b0; kv_m = 1'b1;
        check("kv_set_by_last_write", key_valid, 1'b1);

        // Reset asserted while the fetch sits in REQ
        chk_en = 1'b0;
        @(posedge clk); #1;
        cpu_a = 16'h0300; cpu_m1_n = 1'b0; cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_req_before", rom_req, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_rom_req", rom_req, 1'b0);
        check("midrst_wait_n", cpu_wait_n, 1'b1);
        check("midrst_cpu_di", cpu_di, 8'hFF);
        check("midrst_rom_addr", rom_addr, 16'h0);
        check("midrst_dec_a", dec_a, 16'h0);
        check("midrst_dec_m1", dec_m1, 1'b0);
        check("midrst_dec_prog_d", dec_prog_d, 8'h0);
        check("midrst_dec_key_d", dec_key_d, 8'h0);
        check("midrst_key_valid", key_valid, 1'b0);
        check("midrst_rom_timeout", rom_timeout, 1'b0);
        cpu_mreq_n = 1'b1; cpu_rd_n = 1'b1;
        @(posedge clk); #1;
        reset_n = 1'b1;
        kv_m = 1'b0; c_vld = 1'b0; prog_m = 8'h00;
        chk_en = 1'b1;

        // Repeated fetch of the same location
        do_fetch(16'h0010, 1'b1, 8'h42, 2, 0, 8'h00);
        check("repeat_first_di", cpu_di, 8'h42);
        do_fetch(16'h0010, 1'b1, 8'h42, 2, 0, 8'h00);
        check("repeat_second_di", cpu_di, 8'h42);
`ifdef MC8123_FETCH_CACHE_EN
        check("cache_hit_no_wait", wlo_cnt, 0);
`else
        check("no_cache_wait_low", wlo_cnt, 3);
`endif

        repeat (2) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
